fc_l2_port_arbiter: RTL and testbench



---
 rtl/fc_l2_port_arbiter_pkg.sv | 27 ++
 rtl/fc_l2_port_arbiter_if.sv | 32 +++
 rtl/fc_l2_port_arbiter_id_fifo.sv | 66 ++++++
 rtl/fc_l2_port_arbiter.sv | 123 ++++++++++++
 tb/tb_fc_l2_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_l2_port_arbiter_pkg.sv
// fc_arb_pkg: shared sizing, index type and request-beat struct
// for the FC L2 port arbiter slice (interface, ID FIFO, top).
package fc_arb_pkg;

   localparam int unsigned ARB_N_REQ           = 2;
   localparam int unsigned ARB_ADDR_WIDTH      = 32;
   localparam int unsigned ARB_DATA_WIDTH      = 32;
   localparam int unsigned ARB_BE_WIDTH        = ARB_DATA_WIDTH / 8;
   localparam int unsigned ARB_MAX_OUTSTANDING = 2;

   // $clog2 clamped to 1 so a requester index is never zero bits wide.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned ARB_IDX_WIDTH = idx_width(ARB_N_REQ);

   typedef logic [ARB_IDX_WIDTH-1:0] idx_t;

   typedef struct packed {
      logic [ARB_ADDR_WIDTH-1:0] add;
      logic                      wen;
      logic [ARB_DATA_WIDTH-1:0] wdata;
      logic [ARB_BE_WIDTH-1:0]   be;
   } beat_t;

endpackage

// File: rtl/fc_l2_port_arbiter_if.sv
// TCDM-style bus bundle, N lanes wide. master drives the request
// beat; slave drives gnt, r_valid and the broadcast r_rdata.
interface fc_l2_port_arbiter_if
   import fc_arb_pkg::*;
#(
   parameter int unsigned N  = 1,
   parameter int unsigned AW = ARB_ADDR_WIDTH,
   parameter int unsigned DW = ARB_DATA_WIDTH
);

   localparam int unsigned BW = DW / 8;

   logic [N-1:0]         req;
   logic [N-1:0][AW-1:0] add;
   logic [N-1:0]         wen;
   logic [N-1:0][DW-1:0] wdata;
   logic [N-1:0][BW-1:0] be;
   logic [N-1:0]         gnt;
   logic [N-1:0]         r_valid;
   logic [DW-1:0]        r_rdata;

   modport master (
      output req, add, wen, wdata, be,
      input  gnt, r_valid, r_rdata
   );

   modport slave (
      input  req, add, wen, wdata, be,
      output gnt, r_valid, r_rdata
   );

endinterface

// File: rtl/fc_l2_port_arbiter_id_fifo.sv
// fc_arb_id_fifo: in-order FIFO of granted requester indices.
// Ports: clk_i, rst_ni, push/push_data, pop/pop_data, full, empty, count.
module fc_arb_id_fifo
   import fc_arb_pkg::*;
#(
   parameter int unsigned DEPTH = ARB_MAX_OUTSTANDING
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    push,
   input  idx_t                    push_data,
   input  logic                    pop,
   output idx_t                    pop_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef logic [PW-1:0] ptr_t;

   idx_t          mem [DEPTH];
   ptr_t          wr_ptr_q;
   ptr_t          rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic          do_push;
   logic          do_pop;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   assign full     = (cnt_q == CW'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign count    = cnt_q;
   assign pop_data = mem[rd_ptr_q];
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr_q] <= push_data;
            wr_ptr_q      <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/fc_l2_port_arbiter.sv
// fc_l2_port_arbiter: round-robin share of one L2 master port with grant lock.
// Ports: clk_i, rst_ni, slv (N_REQ requesters), mst (L2 port), outstanding_o, err_o.
module fc_l2_port_arbiter
   import fc_arb_pkg::*;
#(
   parameter int unsigned N_REQ           = fc_arb_pkg::ARB_N_REQ,
   parameter int unsigned ADDR_WIDTH      = fc_arb_pkg::ARB_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH      = fc_arb_pkg::ARB_DATA_WIDTH,
   parameter int unsigned MAX_OUTSTANDING = fc_arb_pkg::ARB_MAX_OUTSTANDING
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   fc_l2_port_arbiter_if.slave               slv,
   fc_l2_port_arbiter_if.master              mst,
   output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
   output logic                              err_o
);

   // idx_t and beat_t are sized from the package.
   if (N_REQ != ARB_N_REQ || ADDR_WIDTH != ARB_ADDR_WIDTH ||
       DATA_WIDTH != ARB_DATA_WIDTH) begin : g_cfg_check
      $error("fc_l2_port_arbiter: parameters differ from fc_arb_pkg");
   end

   idx_t  rr_ptr_q;
   idx_t  lock_idx_q;
   logic  lock_q;
   logic  err_q;
   idx_t  sel;
   idx_t  head;
   logic  sel_req;
   logic  fifo_full;
   logic  fifo_empty;
   logic  grant;
   logic  pop;
   beat_t beat;

   function automatic idx_t wrap_add(input idx_t base, input int unsigned off);
      int unsigned s;
      s = int'(base) + off;
      return idx_t'(s % N_REQ);
   endfunction

   // Walk from the far end so the nearest requester to rr_ptr wins.
   always_comb begin
      sel     = rr_ptr_q;
      sel_req = 1'b0;
      if (lock_q) begin
         sel     = lock_idx_q;
         sel_req = slv.req[lock_idx_q];
      end else begin
         for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (slv.req[wrap_add(rr_ptr_q, k)]) begin
               sel     = wrap_add(rr_ptr_q, k);
               sel_req = 1'b1;
            end
         end
      end
   end

   assign beat = '{
      add:   slv.add[sel],
      wen:   slv.wen[sel],
      wdata: slv.wdata[sel],
      be:    slv.be[sel]
   };

   assign mst.req[0]   = sel_req & ~fifo_full;
   assign mst.add[0]   = beat.add;
   assign mst.wen[0]   = beat.wen;
   assign mst.wdata[0] = beat.wdata;
   assign mst.be[0]    = beat.be;

   assign grant = mst.gnt[0] & mst.req[0];
   assign pop   = mst.r_valid[0] & ~fifo_empty;

   always_comb begin
      slv.gnt     = '0;
      slv.r_valid = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         slv.gnt[i]     = grant & (sel == idx_t'(i));
         slv.r_valid[i] = pop & (head == idx_t'(i));
      end
   end

   assign slv.r_rdata = mst.r_rdata;
   assign err_o       = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         err_q      <= 1'b0;
      end else begin
         if (grant) begin
            rr_ptr_q <= wrap_add(sel, 1);
            lock_q   <= 1'b0;
         end else if (mst.req[0]) begin
            lock_q     <= 1'b1;
            lock_idx_q <= sel;
         end
         if (mst.r_valid[0] && fifo_empty) begin
            err_q <= 1'b1;
         end
      end
   end

   fc_arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) i_id_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push      (grant),
      .push_data (sel),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (outstanding_o)
   );

endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// Bench for fc_l2_port_arbiter: directed cycles, response scoreboard
// checked by a monitor, direct checks of grant/lock/full/error/reset.
module tb_fc_l2_port_arbiter;
   import fc_arb_pkg::*;

   typedef struct {
      int unsigned idx;
      logic [31:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] outstanding;
   logic       err;
   exp_t       sb[$];
   exp_t       mon_e;
   int         total = 0;
   int         bad = 0;

   fc_l2_port_arbiter_if #(.N(2), .AW(32), .DW(32)) slv();
   fc_l2_port_arbiter_if #(.N(1), .AW(32), .DW(32)) mst();

   fc_l2_port_arbiter #(
      .N_REQ           (2),
      .ADDR_WIDTH      (32),
      .DATA_WIDTH      (32),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .slv           (slv),
      .mst           (mst),
      .outstanding_o (outstanding),
      .err_o         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] req, input logic gnt,
                        input logic rv, input logic [31:0] rd);
      slv.req       = req;
      mst.gnt       = gnt;
      mst.r_valid   = rv;
      mst.r_rdata   = rd;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_rsp(input int unsigned idx, input logic [31:0] d);
      sb.push_back('{idx, d});
   endtask

   // Response monitor: every routed r_valid must match the next expected.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && slv.r_valid !== 2'b00) begin
         if (sb.size() == 0) begin
            chk("rvalid_unexpected", 64'(slv.r_valid), 64'h0);
         end else begin
            mon_e = sb.pop_front();
            chk("rvalid_route", 64'(slv.r_valid), 64'h1 << mon_e.idx);
            chk("rdata", 64'(slv.r_rdata), 64'(mon_e.data));
         end
      end
   end

   initial begin
      rst_n         = 1'b0;
      slv.req       = '0;
      slv.add[0]    = 32'h100;
      slv.add[1]    = 32'h200;
      slv.wen       = 2'b11;
      slv.wdata[0]  = 32'h0;
      slv.wdata[1]  = 32'h0;
      slv.be[0]     = 4'hF;
      slv.be[1]     = 4'hF;
      mst.gnt       = '0;
      mst.r_valid   = '0;
      mst.r_rdata   = '0;

      @(negedge clk);
      chk("rst_outstanding", 64'(outstanding), 64'h0);
      chk("rst_err", 64'(err), 64'h0);
      chk("rst_mst_req", 64'(mst.req), 64'h0);
      chk("rst_gnt", 64'(slv.gnt), 64'h0);
      chk("rst_rvalid", 64'(slv.r_valid), 64'h0);
      rst_n = 1'b1;
      next();

      // Round-robin with gnt tied high, responses trailing by one cycle.
      drive(2'b11, 1'b1, 1'b0, 32'h0); expect_rsp(0, 32'hA0);
      @(negedge clk);
      chk("rr_gnt_a", 64'(slv.gnt), 64'h1);
      chk("rr_add_a", 64'(mst.add), 64'h100);
      next();
      drive(2'b11, 1'b1, 1'b1, 32'hA0); expect_rsp(1, 32'hA1);
      @(negedge clk);
      chk("rr_gnt_b", 64'(slv.gnt), 64'h2);
      chk("rr_add_b", 64'(mst.add), 64'h200);
      chk("rr_occ_b", 64'(outstanding), 64'h1);
      next();
      drive(2'b11, 1'b1, 1'b1, 32'hA1); expect_rsp(0, 32'hA2);
      @(negedge clk);
      chk("rr_gnt_c", 64'(slv.gnt), 64'h1);
      next();
      drive(2'b11, 1'b1, 1'b1, 32'hA2); expect_rsp(1, 32'hA3);
      @(negedge clk);
      chk("rr_gnt_d", 64'(slv.gnt), 64'h2);
      next();
      drive(2'b00, 1'b0, 1'b1, 32'hA3);
      @(negedge clk);
      chk("rr_occ_e", 64'(outstanding), 64'h1);
      next();
      drive(2'b00, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("rr_occ_f", 64'(outstanding), 64'h0);
      next();

      // Lock: gnt low for 3 cycles, requester 0 stays presented.
      slv.add[0] = 32'h300;
      slv.add[1] = 32'h400;
      for (int c = 0; c < 3; c++) begin
         drive(2'b11, 1'b0, 1'b0, 32'h0);
         @(negedge clk);
         chk("lock_add_wait", 64'(mst.add), 64'h300);
         chk("lock_no_gnt", 64'(slv.gnt), 64'h0);
         next();
      end
      drive(2'b11, 1'b1, 1'b0, 32'h0); expect_rsp(0, 32'hB0);
      @(negedge clk);
      chk("lock_add_gnt", 64'(mst.add), 64'h300);
      chk("lock_gnt0", 64'(slv.gnt), 64'h1);
      next();
      drive(2'b11, 1'b1, 1'b0, 32'h0); expect_rsp(1, 32'hB1);
      @(negedge clk);
      chk("lock_gnt1", 64'(slv.gnt), 64'h2);
      chk("lock_add1", 64'(mst.add), 64'h400);
      next();
      drive(2'b00, 1'b0, 1'b1, 32'hB0);
      @(negedge clk);
      next();
      drive(2'b00, 1'b0, 1'b1, 32'hB1);
      @(negedge clk);
      next();

      // Locked requester drops req: nothing is granted to the other one.
      drive(2'b01, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("viol_req_on", 64'(mst.req), 64'h1);
      next();
      drive(2'b10, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("viol_req_off", 64'(mst.req), 64'h0);
      chk("viol_no_gnt", 64'(slv.gnt), 64'h0);
      next();
      drive(2'b11, 1'b1, 1'b0, 32'h0); expect_rsp(0, 32'hC0);
      @(negedge clk);
      chk("viol_gnt0", 64'(slv.gnt), 64'h1);
      next();
      drive(2'b00, 1'b0, 1'b1, 32'hC0);
      @(negedge clk);
      next();

      // Single read.
      slv.add[0] = 32'h1C000100;
      drive(2'b01, 1'b1, 1'b0, 32'h0); expect_rsp(0, 32'hDEADBEEF);
      @(negedge clk);
      chk("rd_gnt", 64'(slv.gnt), 64'h1);
      chk("rd_add", 64'(mst.add), 64'h1C000100);
      chk("rd_wen", 64'(mst.wen), 64'h1);
      next();
      drive(2'b00, 1'b0, 1'b1, 32'hDEADBEEF);
      @(negedge clk);
      chk("rd_occ1", 64'(outstanding), 64'h1);
      next();
      drive(2'b00, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("rd_occ0", 64'(outstanding), 64'h0);
      next();

      // Full: two grants, then no grant until the cycle after a pop.
      drive(2'b11, 1'b1, 1'b0, 32'h0); expect_rsp(1, 32'hD0);
      @(negedge clk);
      chk("full_gnt_a", 64'(slv.gnt), 64'h2);
      next();
      drive(2'b11, 1'b1, 1'b0, 32'h0); expect_rsp(0, 32'hD1);
      @(negedge clk);
      chk("full_gnt_b", 64'(slv.gnt), 64'h1);
      next();
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("full_mst_req", 64'(mst.req), 64'h0);
      chk("full_no_gnt", 64'(slv.gnt), 64'h0);
      chk("full_occ", 64'(outstanding), 64'h2);
      next();
      drive(2'b11, 1'b1, 1'b1, 32'hD0);
      @(negedge clk);
      chk("full_pop_no_gnt", 64'(slv.gnt), 64'h0);
      chk("full_pop_no_req", 64'(mst.req), 64'h0);
      next();
      drive(2'b11, 1'b1, 1'b0, 32'h0); expect_rsp(1, 32'hD2);
      @(negedge clk);
      chk("full_next_gnt", 64'(slv.gnt), 64'h2);
      chk("full_next_occ", 64'(outstanding), 64'h1);
      next();
      drive(2'b00, 1'b0, 1'b1, 32'hD1);
      @(negedge clk);
      next();
      drive(2'b00, 1'b0, 1'b1, 32'hD2);
      @(negedge clk);
      next();
      drive(2'b00, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("full_drain", 64'(outstanding), 64'h0);
      next();

      // Mixed order: write req1, read req0, read req1.
      slv.wen[1] = 1'b0;
      drive(2'b10, 1'b1, 1'b0, 32'h0); expect_rsp(1, 32'hE0);
      @(negedge clk);
      chk("mix_gnt_a", 64'(slv.gnt), 64'h2);
      chk("mix_wen_a", 64'(mst.wen), 64'h0);
      next();
      drive(2'b01, 1'b1, 1'b0, 32'h0); expect_rsp(0, 32'hE1);
      @(negedge clk);
      chk("mix_gnt_b", 64'(slv.gnt), 64'h1);
      chk("mix_wen_b", 64'(mst.wen), 64'h1);
      next();
      slv.wen[1] = 1'b1;
      drive(2'b10, 1'b1, 1'b1, 32'hE0);
      @(negedge clk);
      chk("mix_full", 64'(slv.gnt), 64'h0);
      next();
      drive(2'b10, 1'b1, 1'b0, 32'h0); expect_rsp(1, 32'hE2);
      @(negedge clk);
      chk("mix_gnt_c", 64'(slv.gnt), 64'h2);
      chk("mix_wen_c", 64'(mst.wen), 64'h1);
      next();
      drive(2'b00, 1'b0, 1'b1, 32'hE1);
      @(negedge clk);
      next();
      drive(2'b00, 1'b0, 1'b1, 32'hE2);
      @(negedge clk);
      next();
      drive(2'b00, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      next();

      // Response with empty FIFO, then a spurious gnt.
      drive(2'b00, 1'b0, 1'b1, 32'h55);
      @(negedge clk);
      chk("err_no_rvalid", 64'(slv.r_valid), 64'h0);
      chk("err_not_yet", 64'(err), 64'h0);
      next();
      drive(2'b00, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("err_set", 64'(err), 64'h1);
      chk("spur_no_gnt", 64'(slv.gnt), 64'h0);
      next();
      drive(2'b00, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("spur_occ", 64'(outstanding), 64'h0);
      chk("err_sticky", 64'(err), 64'h1);
      next();

      // Async reset with two transactions in flight.
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("rst_burst_a", 64'(slv.gnt), 64'h1);
      next();
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("rst_burst_b", 64'(slv.gnt), 64'h2);
      next();
      drive(2'b00, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("rst_pre_occ", 64'(outstanding), 64'h2);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_occ", 64'(outstanding), 64'h0);
      chk("rst_async_err", 64'(err), 64'h0);
      #1 rst_n = 1'b1;
      next();
      drive(2'b00, 1'b0, 1'b1, 32'h77);
      @(negedge clk);
      chk("late_rsp_drop", 64'(slv.r_valid), 64'h0);
      next();
      drive(2'b00, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("late_rsp_err", 64'(err), 64'h1);
      chk("sb_drained", 64'(sb.size()), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
